spi_master_ctrl: RTL and testbench

//  Master-side sequencer for the SPI byte shift register. It generates SCLK from pclk and drives
//  ss, senddata and receivedata. It also produces the four one-cycle edge flags
//  (flaglow/flaghigh/flagslow/flagshigh) that advance the shift register's bit counters.

---
 rtl/spi_pkg.sv | 14 +
 rtl/spi_baud_gen.sv | 49 ++++
 rtl/spi_master_ctrl.sv | 131 +++++++++++++
 tb/tb_spi_master_ctrl.sv | 249 ++++++++++++++++++++++++
 4 files changed

// File: rtl/spi_pkg.sv
// Shared types and constants for the SPI master sequencer.
package spi_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    LOAD = 2'd1,
    XFER = 2'd2,
    DONE = 2'd3
  } spi_state_t;

  localparam int EDGES_PER_BYTE = 16;
  localparam int DIV_W_DEF      = 12;

endpackage

// File: rtl/spi_baud_gen.sv
// SCLK half-period divider, SCLK register and the four edge-flag decodes.
module spi_baud_gen #(
  parameter int DIV_W = 12
) (
  input  logic             pclk,
  input  logic             preset,
  input  logic             i_en,
  input  logic             i_rest,
  input  logic [DIV_W-1:0] i_div,
  output logic             o_sclk,
  output logic             o_toggle,
  output logic             o_flaglow,
  output logic             o_flaghigh,
  output logic             o_flagslow,
  output logic             o_flagshigh
);

  logic [DIV_W-1:0] r_div_cnt;
  logic             r_sclk;
  logic             w_at_end;
  logic             w_at_pre;

  assign w_at_end = (r_div_cnt == i_div);
  assign w_at_pre = (r_div_cnt == (i_div - DIV_W'(1)));

  // When disabled the clock is parked at the rest level so an abort lands on cpol.
  always_ff @(posedge pclk or posedge preset) begin
    if (preset) begin
      r_div_cnt <= '0;
      r_sclk    <= 1'b0;
    end else if (!i_en) begin
      r_div_cnt <= '0;
      r_sclk    <= i_rest;
    end else if (w_at_end) begin
      r_div_cnt <= '0;
      r_sclk    <= ~r_sclk;
    end else begin
      r_div_cnt <= r_div_cnt + DIV_W'(1);
    end
  end

  assign o_sclk      = r_sclk;
  assign o_toggle    = i_en & w_at_end;
  assign o_flaglow   = i_en & w_at_end & ~r_sclk;
  assign o_flaghigh  = i_en & w_at_end &  r_sclk;
  assign o_flagslow  = i_en & w_at_pre & ~r_sclk;
  assign o_flagshigh = i_en & w_at_pre &  r_sclk;

endmodule

// File: rtl/spi_master_ctrl.sv
// SPI master sequencer: FSM, edge counter and baud_div shadow around spi_baud_gen.
// Optional SPI_IRQ_EN adds a sticky done interrupt (spi_irq) with clear input irq_clr.
//
// state | meaning
// IDLE  | ss high, sclk follows cpol, waiting for spe & send_req
// LOAD  | one cycle: senddata pulse, ss low, shadow baud_div captured
// XFER  | sclk toggling, EDGES edges counted
// DONE  | one cycle: receivedata/done pulse, ss released on exit
module spi_master_ctrl
  import spi_pkg::*;
#(
  parameter int DIV_W = DIV_W_DEF,
  parameter int EDGES = EDGES_PER_BYTE
) (
  input  logic             pclk,
  input  logic             preset,
  input  logic             spe,
  input  logic             cpol,
  input  logic             cpha,
  input  logic [DIV_W-1:0] baud_div,
  input  logic             send_req,
  output logic             sclk,
  output logic             ss,
  output logic             senddata,
  output logic             receivedata,
  output logic             flaglow,
  output logic             flaghigh,
  output logic             flagslow,
  output logic             flagshigh,
  output logic             busy,
  output logic             done
`ifdef SPI_IRQ_EN
  ,
  output logic             spi_irq,
  input  logic             irq_clr
`endif
);

  localparam int EW = $clog2(EDGES) + 1;

  spi_state_t       r_state;
  spi_state_t       w_next;
  logic [DIV_W-1:0] r_div;
  logic [EW-1:0]    r_edge_cnt;
  logic             w_run;
  logic             w_toggle;
  logic             w_unused_cpha;

  // Both clock phases are served by the edge flags, so cpha needs no logic here.
  assign w_unused_cpha = cpha;

  assign w_run = (r_state == XFER) & spe;

  always_ff @(posedge pclk or posedge preset) begin
    if (preset) begin
      r_state <= IDLE;
    end else begin
      r_state <= w_next;
    end
  end

  always_comb begin
    w_next = r_state;
    case (r_state)
      IDLE: if (spe && send_req) w_next = LOAD;
      LOAD: w_next = spe ? XFER : IDLE;
      XFER: begin
        if (!spe) begin
          w_next = IDLE;
        end else if (w_toggle && (r_edge_cnt == EW'(EDGES - 1))) begin
          w_next = DONE;
        end
      end
      DONE: w_next = IDLE;
      default: w_next = IDLE;
    endcase
  end

  always_ff @(posedge pclk or posedge preset) begin
    if (preset) begin
      r_div      <= DIV_W'(1);
      r_edge_cnt <= '0;
    end else begin
      if (r_state == LOAD) begin
        r_div <= (baud_div == '0) ? DIV_W'(1) : baud_div;
      end
      if (r_state != XFER) begin
        r_edge_cnt <= '0;
      end else if (w_toggle) begin
        r_edge_cnt <= r_edge_cnt + EW'(1);
      end
    end
  end

  spi_baud_gen #(.DIV_W(DIV_W)) u_baud (
    .pclk        (pclk),
    .preset      (preset),
    .i_en        (w_run),
    .i_rest      (cpol),
    .i_div       (r_div),
    .o_sclk      (sclk),
    .o_toggle    (w_toggle),
    .o_flaglow   (flaglow),
    .o_flaghigh  (flaghigh),
    .o_flagslow  (flagslow),
    .o_flagshigh (flagshigh)
  );

  assign busy        = (r_state != IDLE);
  assign ss          = ~busy;
  assign senddata    = (r_state == LOAD);
  assign receivedata = (r_state == DONE);
  assign done        = receivedata;

`ifdef SPI_IRQ_EN
  logic r_irq;

  always_ff @(posedge pclk or posedge preset) begin
    if (preset) begin
      r_irq <= 1'b0;
    end else if (irq_clr) begin
      r_irq <= 1'b0;
    end else if (done) begin
      r_irq <= 1'b1;
    end
  end

  assign spi_irq = r_irq;
`endif

endmodule

// File: tb/tb_spi_master_ctrl.sv
// Directed bench for spi_master_ctrl; hand-computed expectations, optional SPI_IRQ_EN checks.
module tb_spi_master_ctrl;

  localparam int DIV_W = 12;

  logic             pclk;
  logic             preset;
  logic             spe;
  logic             cpol;
  logic             cpha;
  logic [DIV_W-1:0] baud_div;
  logic             send_req;
  logic             sclk;
  logic             ss;
  logic             senddata;
  logic             receivedata;
  logic             flaglow;
  logic             flaghigh;
  logic             flagslow;
  logic             flagshigh;
  logic             busy;
  logic             done;
`ifdef SPI_IRQ_EN
  logic             spi_irq;
  logic             irq_clr;
`endif

  int n_chk  = 0;
  int n_pass = 0;

  int t_done_at, t_lat, t_tog, t_fl, t_fh, t_fsl, t_fsh;
  int t_send, t_recv, t_xcyc, t_lead, t_mis, t_first;

  spi_master_ctrl #(.DIV_W(DIV_W), .EDGES(16)) dut (
    .pclk        (pclk),
    .preset      (preset),
    .spe         (spe),
    .cpol        (cpol),
    .cpha        (cpha),
    .baud_div    (baud_div),
    .send_req    (send_req),
    .sclk        (sclk),
    .ss          (ss),
    .senddata    (senddata),
    .receivedata (receivedata),
    .flaglow     (flaglow),
    .flaghigh    (flaghigh),
    .flagslow    (flagslow),
    .flagshigh   (flagshigh),
    .busy        (busy),
    .done        (done)
`ifdef SPI_IRQ_EN
    ,
    .spi_irq     (spi_irq),
    .irq_clr     (irq_clr)
`endif
  );

  initial pclk = 1'b0;
  always #5 pclk = ~pclk;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_chk++;
    if (obs === exp) n_pass++;
    else $display("FAIL %s: got %0d expected %0d", tag, obs, exp);
  endtask

  task automatic tick();
    @(posedge pclk);
    #1;
  endtask

  // Called while the LOAD cycle is being sampled; walks to the first IDLE sample.
  // cycle 1 = LOAD sample, so latency LOAD->IDLE = final cycle - 1.
  task automatic xfer(input int mid_div, input logic keep_req);
    int   cyc;
    logic p_sclk;
    logic p_fsh;
    t_done_at = 0; t_tog = 0; t_fl = 0; t_fh = 0; t_fsl = 0; t_fsh = 0;
    t_send = 0; t_recv = 0; t_xcyc = 0; t_lead = 0; t_mis = 0; t_first = 2;
    cyc    = 0;
    p_sclk = sclk;
    p_fsh  = 1'b0;
    while (1) begin
      cyc++;
      if (sclk != p_sclk) begin
        t_tog++;
        if (t_first == 2) t_first = int'(sclk);
      end
      t_fl  += int'(flaglow);
      t_fh  += int'(flaghigh);
      t_fsl += int'(flagslow);
      t_fsh += int'(flagshigh);
      t_send += int'(senddata);
      t_recv += int'(receivedata);
      if (done !== receivedata) t_mis++;
      if (done && t_done_at == 0) t_done_at = cyc;
      if (busy && !senddata && !receivedata) t_xcyc++;
      if (p_fsh && flaghigh) t_lead++;
      p_sclk = sclk;
      p_fsh  = flagshigh;
      if (!busy || cyc >= 300) break;
      if (cyc == 1) send_req = keep_req;
      if (cyc == 10 && mid_div >= 0) baud_div = DIV_W'(mid_div);
      tick();
    end
    t_lat = cyc - 1;
    check("xfer_terminates", busy, 1'b0);
  endtask

  initial begin
    int n;
    int g;
    logic p;
    preset = 1'b1; spe = 1'b0; cpol = 1'b0; cpha = 1'b0;
    baud_div = DIV_W'(1); send_req = 1'b0;
`ifdef SPI_IRQ_EN
    irq_clr = 1'b0;
`endif
    #1;
    check("rst_ss", ss, 1'b1);
    check("rst_sclk", sclk, 1'b0);
    check("rst_busy", busy, 1'b0);
    check("rst_done", done, 1'b0);
    check("rst_senddata", senddata, 1'b0);
    repeat (2) tick();
    preset = 1'b0; spe = 1'b1;
    tick();

    // Mode 0, baud_div=1
    check("m0_idle_sclk", sclk, 1'b0);
    send_req = 1'b1;
    tick();
    check("m0_load_senddata", senddata, 1'b1);
    check("m0_load_ss", ss, 1'b0);
    xfer(-1, 1'b0);
    check("m0_done_at", t_done_at, 34);
    check("m0_latency", t_lat, 34);
    check("m0_toggles", t_tog, 16);
    check("m0_flaglow", t_fl, 8);
    check("m0_flaghigh", t_fh, 8);
    check("m0_flagslow", t_fsl, 8);
    check("m0_flagshigh", t_fsh, 8);
    check("m0_senddata_cnt", t_send, 1);
    check("m0_recv_cnt", t_recv, 1);
    check("m0_done_eq_recv", t_mis, 0);
    check("m0_xfer_cycles", t_xcyc, 32);
    check("m0_ss_after", ss, 1'b1);
    check("m0_sclk_after", sclk, 1'b0);
`ifdef SPI_IRQ_EN
    check("irq_set", spi_irq, 1'b1);
    tick();
    check("irq_sticky", spi_irq, 1'b1);
    irq_clr = 1'b1;
    tick();
    check("irq_cleared", spi_irq, 1'b0);
`endif

    // Mode 3, baud_div=3; cpol reaches sclk one cycle after it changes
    cpol = 1'b1; cpha = 1'b1; baud_div = DIV_W'(3);
    check("m3_cpol_lag", sclk, 1'b0);
    tick();
    check("m3_idle_sclk", sclk, 1'b1);
    send_req = 1'b1;
    tick();
    xfer(-1, 1'b0);
    check("m3_first_edge_falls", t_first, 0);
    check("m3_xfer_cycles", t_xcyc, 64);
    check("m3_toggles", t_tog, 16);
    check("m3_lead", t_lead, 8);
    check("m3_flaghigh", t_fh, 8);
    check("m3_done_at", t_done_at, 66);
    check("m3_sclk_after", sclk, 1'b1);
`ifdef SPI_IRQ_EN
    check("irq_clr_wins", spi_irq, 1'b0);
    irq_clr = 1'b0;
`endif

    // Abort after 5 toggles, cpol=1
    cpha = 1'b0; baud_div = DIV_W'(1);
    send_req = 1'b1;
    tick();
    send_req = 1'b0;
    n = 0; g = 0; p = sclk;
    while (n < 5 && g < 100) begin
      tick();
      g++;
      if (sclk != p) n++;
      p = sclk;
    end
    check("ab_toggles_seen", n, 5);
    check("ab_sclk_before", sclk, 1'b0);
    spe = 1'b0;
    tick();
    check("ab_busy", busy, 1'b0);
    check("ab_ss", ss, 1'b1);
    check("ab_sclk", sclk, 1'b1);
    n = 0;
    repeat (5) begin
      n += int'(done) + int'(receivedata);
      tick();
    end
    check("ab_no_done", n, 0);
    spe = 1'b1;

    // Back-to-back with send_req held; baud_div change mid-XFER waits for next LOAD
    cpol = 1'b0;
    tick();
    send_req = 1'b1;
    tick();
    xfer(3, 1'b1);
    check("bb_first_done_at", t_done_at, 34);
    g = 0; n = 0;
    while (!senddata && n < 10) begin
      if (ss) g++;
      n++;
      tick();
    end
    check("bb_gap", g, 1);
    xfer(-1, 1'b0);
    check("bb_second_done_at", t_done_at, 66);

    // Async reset mid-XFER with sclk high
    send_req = 1'b1;
    tick();
    send_req = 1'b0;
    repeat (5) tick();
    check("rx_pre_sclk", sclk, 1'b1);
    check("rx_pre_busy", busy, 1'b1);
    preset = 1'b1;
    #1;
    check("rx_ss", ss, 1'b1);
    check("rx_sclk", sclk, 1'b0);
    check("rx_busy", busy, 1'b0);
    check("rx_recv", receivedata, 1'b0);
    repeat (2) tick();
    preset = 1'b0;
    n = 0;
    repeat (80) begin
      n += int'(receivedata) + int'(busy);
      tick();
    end
    check("rx_no_resume", n, 0);

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule
